// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_pkg
//  Description : Shared definitions for the BRAM arbiter slice: requester-id
//                encoding, arbiter state encoding and default RAM geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

    // Default RAM geometry: 2048 x 8
    localparam int c_DEFAULT_ADDR_W = 11;
    localparam int c_DEFAULT_DATA_W = 8;

    // Requester identity carried alongside each read through the tag pipe
    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } req_id_t;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_t;

endpackage : bram_pkg
`default_nettype wire

// File: rtl/bram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rd_tag_pipe
//  Description : READ_LAT-deep shift register carrying (valid, id) tags for
//                reads issued to the RAM, so the returning ram_dout can be
//                steered to the requester that issued it.
//  Ports       : clk_in   - clock, rising edge
//                btn_rst  - asynchronous active-low reset (clears all tags)
//                push_vld - a read was granted this cycle
//                push_id  - requester that owns that read
//                pop_vld  - tag emerging READ_LAT cycles after push
//                pop_id   - requester of the emerging tag
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_tag_pipe
    import bram_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic    clk_in,
    input  logic    btn_rst,
    input  logic    push_vld,
    input  req_id_t push_id,
    output logic    pop_vld,
    output req_id_t pop_id
);

    logic [READ_LAT-1:0] r_vld;
    req_id_t             r_id [READ_LAT];

    // Stage 0 captures the new tag
    always_ff @(posedge clk_in or negedge btn_rst) begin
        if (!btn_rst) begin
            r_vld[0] <= 1'b0;
            r_id[0]  <= ID_A;
        end else begin
            r_vld[0] <= push_vld;
            r_id[0]  <= push_id;
        end
    end

    // Remaining stages only shift; absent when READ_LAT is 1
    for (genvar s = 1; s < READ_LAT; s++) begin : g_stage
        always_ff @(posedge clk_in or negedge btn_rst) begin
            if (!btn_rst) begin
                r_vld[s] <= 1'b0;
                r_id[s]  <= ID_A;
            end else begin
                r_vld[s] <= r_vld[s-1];
                r_id[s]  <= r_id[s-1];
            end
        end
    end

    assign pop_vld = r_vld[READ_LAT-1];
    assign pop_id  = r_id[READ_LAT-1];

endmodule : bram_rd_tag_pipe
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_arbiter
//  Description : Two-requester round-robin arbiter in front of a single-port
//                synchronous RAM, with locked bursts bounded by MAX_LOCK and
//                read-return steering through a tag pipeline.
//  Ports       : clk_in, btn_rst (async, active-low)
//                a_*/b_*  - requester request/we/lock/addr/wdata in,
//                           gnt/rvalid/rdata out
//                ram_*    - RAM ce/wre/ad/din out, dout in
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter
    import bram_pkg::*;
#(
    parameter int ADDR_W   = c_DEFAULT_ADDR_W,
    parameter int DATA_W   = c_DEFAULT_DATA_W,
    parameter int READ_LAT = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk_in,
    input  logic              btn_rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int c_CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t         r_state, w_state_nxt;
    req_id_t            r_prio,  w_prio_nxt;   // winner when both request
    logic [c_CNT_W-1:0] r_lock_cnt, w_cnt_nxt, w_cnt_inc;

    logic    w_gnt_a, w_gnt_b, w_win_lock, w_rd_push;
    logic    w_pop_vld;
    req_id_t w_pop_id, w_push_id;

    always_ff @(posedge clk_in or negedge btn_rst) begin
        if (!btn_rst) begin
            r_state    <= ST_IDLE;
            r_prio     <= ID_A;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_lock_cnt <= w_cnt_nxt;
        end
    end

    assign w_cnt_inc = r_lock_cnt + 1'b1;

    always_comb begin
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_prio_nxt  = r_prio;

        case (r_state)
            ST_OWN_A: w_gnt_a = a_req;
            ST_OWN_B: w_gnt_b = b_req;
            default: begin
                if (a_req && (!b_req || r_prio == ID_A)) begin
                    w_gnt_a = 1'b1;
                end else if (b_req) begin
                    w_gnt_b = 1'b1;
                end
            end
        endcase

        // Grants are combinational, so they must also be masked while the
        // asynchronous reset is held
        if (!btn_rst) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end

        w_win_lock = w_gnt_a ? a_lock : b_lock;

        if (w_gnt_a || w_gnt_b) begin
            if (w_gnt_a) begin
                w_prio_nxt = ID_B;
            end else begin
                w_prio_nxt = ID_A;
            end
            // Ownership is kept only while the burst is below its ceiling;
            // the MAX_LOCK-th locked grant always drops back to IDLE
            if (w_win_lock && (w_cnt_inc < c_CNT_W'(MAX_LOCK))) begin
                w_state_nxt = w_gnt_a ? ST_OWN_A : ST_OWN_B;
                w_cnt_nxt   = w_cnt_inc;
            end
        end
    end

    assign a_gnt   = w_gnt_a;
    assign b_gnt   = w_gnt_b;
    assign ram_ce  = w_gnt_a | w_gnt_b;
    assign ram_wre = (w_gnt_a & a_we) | (w_gnt_b & b_we);
    assign ram_ad  = w_gnt_a ? a_addr  : (w_gnt_b ? b_addr  : '0);
    assign ram_din = w_gnt_a ? a_wdata : (w_gnt_b ? b_wdata : '0);

    assign w_rd_push = ram_ce & ~ram_wre;
    assign w_push_id = w_gnt_b ? ID_B : ID_A;

    bram_rd_tag_pipe #(
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .clk_in   (clk_in),
        .btn_rst  (btn_rst),
        .push_vld (w_rd_push),
        .push_id  (w_push_id),
        .pop_vld  (w_pop_vld),
        .pop_id   (w_pop_id)
    );

    assign a_rvalid = w_pop_vld && (w_pop_id == ID_A);
    assign b_rvalid = w_pop_vld && (w_pop_id == ID_B);
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule : bram_arbiter
`default_nettype wire

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, RAM address width (2048 deep).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter READ_LAT, default 1, RAM clock-to-dout latency in cycles; legal values 1 or 2.
REQ-004 Parameter MAX_LOCK, default 16, maximum consecutive locked grants before forced release.
REQ-005 clk_in  input  1  system clock; all logic on rising edge.
REQ-006 btn_rst  input  1  asynchronous, active-low reset.
REQ-007 a_req, b_req  input  1  requester A/B access request.
REQ-008 a_we, b_we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 a_lock, b_lock  input  1  keep grant for the next access (burst).
REQ-010 a_addr, b_addr  input  ADDR_W  target address.
REQ-011 a_wdata, b_wdata  input  DATA_W  write data.
REQ-012 a_gnt, b_gnt  output  1  access accepted this cycle (combinational).
REQ-013 a_rvalid, b_rvalid  output  1  read data valid for that requester.
REQ-014 a_rdata, b_rdata  output  DATA_W  read data; both driven from ram_dout.
REQ-015 ram_ce, ram_wre  output  1  RAM enable, write enable.
REQ-016 ram_ad  output  ADDR_W  RAM address.
REQ-017 ram_din  output  DATA_W  RAM write data.
REQ-018 ram_dout  input  DATA_W  RAM read data.

Function
REQ-019 At most one of a_gnt/b_gnt SHALL be high in any cycle; gnt is high only while the matching req is high.
REQ-020 The transfer occurs in the gnt cycle: ram_ce=1, ram_ad/ram_din/ram_wre equal the winner's addr/wdata/we; with no grant, ram_ce=0, ram_wre=0.
REQ-021 Arbitration SHALL be round-robin: a single requester wins outright; when both request, the one not granted most recently wins; after reset, A has priority.
REQ-022 Arbiter states: IDLE, OWN_A, OWN_B. A granted access with lock=1 enters/stays in OWN_x; lock=0 or a cycle without the owner's req returns to IDLE.
REQ-023 In OWN_x only requester x can be granted; the other requester's req is held off with gnt=0.
REQ-024 A lock counter counts consecutive locked grants; on the MAX_LOCK-th grant the owner is released to IDLE regardless of lock, and the other requester, if requesting, wins the next cycle.
REQ-025 Each granted read SHALL assert the owner's rvalid for exactly one cycle, READ_LAT cycles after the gnt cycle; writes produce no rvalid.
REQ-026 Read tags (valid, id) SHALL travel a READ_LAT-deep shift register; back-to-back reads from alternating requesters each return in order with no lost or duplicated rvalid.
REQ-027 Address and data pass unmodified; no wrap-around or range check is performed (full ADDR_W space is legal).
REQ-028 Read and write to the same address in consecutive cycles SHALL behave as RAM order dictates (write first, then read returns new data).

Reset
REQ-029 On btn_rst low: state IDLE, priority pointer to A, lock counter 0, read-tag pipeline cleared; a_gnt, b_gnt, rvalids, ram_ce, ram_wre are 0; ram_ad and ram_din are 0.
REQ-030 Reads in flight at reset SHALL be discarded (no rvalid after release).
REQ-031 First grant is possible in the first clock edge after btn_rst deasserts.

Structure
REQ-032 Requester-id encoding and the state encoding SHALL live in shared package bram_pkg, together with default ADDR_W/DATA_W.
REQ-033 Read-tag pipeline SHALL be a separate sub-module bram_rd_tag_pipe (parameter READ_LAT).
REQ-034 RAM macro is instantiated outside this block; arbiter is RAM-vendor-neutral.

Verification
REQ-035 A writes 0xFE to 0x000, then reads 0x000 -> a_gnt each cycle, a_rvalid=1 with a_rdata=0xFE exactly READ_LAT cycles after read gnt.
REQ-036 a_req and b_req held high, no lock, 8 cycles -> grants alternate A,B,A,B... starting with A after reset.
REQ-037 A lock=1 burst of 4 reads 0x010-0x013 with b_req high -> B blocked 4 cycles, granted on 5th; A receives 4 ordered rvalids.
REQ-038 A lock held high indefinitely with b_req high, MAX_LOCK=16 -> B granted on cycle 17.
REQ-039 Alternating A/B reads to 0x7FF and 0x000 with READ_LAT=2 -> rvalids alternate, data matches each address.
REQ-040 btn_rst pulsed low one cycle after a granted read -> no rvalid afterward, all outputs 0 during reset.
